// File: rtl/pwc_pkg.sv
// Shared encodings and parameter checks for the multi-channel pulse-width calculator.
package pwc_pkg;

  typedef enum logic [1:0] {
    WAIT_HIST  = 2'd0,
    WAIT_START = 2'd1,
    RUN        = 2'd2
  } glb_state_t;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } ch_state_t;

  // The channel tag must be able to name every channel.
  function automatic bit ch_bits_ok(input int num_ch, input int ch_bits);
    return (num_ch >= 1) && (num_ch <= 16) && (ch_bits >= 1) &&
           (ch_bits >= $clog2(num_ch));
  endfunction

endpackage

// File: rtl/pwc_channel.sv
// One pulse channel: input synchroniser, ARM/IDLE/MEASURE FSM, saturating
// width counter and a one-deep pending result register.
module pwc_channel
  import pwc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ACCEPT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  pulse_in,
  input  logic                  polarity,
  input  logic                  grant,
  output logic                  pend_vld,
  output logic [DATA_WIDTH-1:0] pend_data,
  output logic                  drop,
  output logic                  sat_hit
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + DATA_WIDTH'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   act_p0;
  ch_state_t              st_q, st_d;
  logic [DATA_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   res_vld_p0, res_ok_p0, load_p1;
  logic                   pend_vld_p1;
  logic [DATA_WIDTH-1:0]  pend_data_p1;

  // Stage p0: synchronised input and measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_p0 <= '0;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pulse_in};
  end

  assign act_p0 = ~(sync_p0[SYNC_STAGES-1] ^ polarity);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_q <= ARM;
    else       st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (!run) begin
      st_d = ARM;
    end else begin
      case (st_q)
        ARM:     if (!act_p0) st_d = IDLE;
        IDLE:    if (act_p0) begin
                   st_d  = MEASURE;
                   cnt_d = DATA_WIDTH'(1);
                 end
        MEASURE: if (act_p0) cnt_d = sat_inc(cnt_q);
                 else        st_d  = IDLE;
        default: st_d = ARM;
      endcase
    end
  end

  always_comb begin
    res_vld_p0 = run && (st_q == MEASURE) && !act_p0;
    sat_hit    = run && (st_q == MEASURE) && act_p0 && (cnt_q == CNT_MAX);
    res_ok_p0  = res_vld_p0 && (cnt_q >= DATA_WIDTH'(MIN_ACCEPT));
    // A grant in the completion cycle frees the slot for the new result.
    load_p1    = res_ok_p0 && (!pend_vld_p1 || grant);
    drop       = res_ok_p0 && pend_vld_p1 && !grant;
  end

  // Stage p1: pending result awaiting arbitration
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pend_vld_p1 <= 1'b0;
    else if (!run)    pend_vld_p1 <= 1'b0;
    else if (load_p1) pend_vld_p1 <= 1'b1;
    else if (grant)   pend_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load_p1) pend_data_p1 <= cnt_q;
  end

  assign pend_vld  = pend_vld_p1;
  assign pend_data = pend_data_p1;

endmodule

// File: rtl/pulse_width_multi.sv
// Multi-channel pulse-width calculator with round-robin merge into one FIFO port.
// Optional build macro PWC_MIN_WIDTH_FILTER_EN silently discards widths below MIN_WIDTH.
module pulse_width_multi
  import pwc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int CH_BITS     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_done_from_hist,
  input  logic [NUM_CH-1:0]     pulse_sig_in,
  input  logic [NUM_CH-1:0]     polarity_sel,
  input  logic                  start_from_pc,
  input  logic                  stop_from_pc,
  output logic [DATA_WIDTH-1:0] data_to_compute_histogram,
  output logic [CH_BITS-1:0]    ch_id_to_fifo,
  output logic                  wrreq_to_FIFO,
  input  logic                  wrfull_from_FIFO,
  output logic [DATA_WIDTH-1:0] drop_count,
  output logic                  sat_flag
);

`ifdef PWC_MIN_WIDTH_FILTER_EN
  localparam int MIN_ACCEPT = MIN_WIDTH;
`else
  localparam int MIN_ACCEPT = 1;
`endif

  if (!ch_bits_ok(NUM_CH, CH_BITS) || (MIN_WIDTH < 1)) begin : g_bad_params
    $error("pulse_width_multi: CH_BITS too narrow for NUM_CH, or MIN_WIDTH < 1");
  end

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input int unsigned b);
    logic [32:0] s;
    s = 33'(a) + 33'(b);
    return (s > 33'(CNT_MAX)) ? CNT_MAX : DATA_WIDTH'(s);
  endfunction

  glb_state_t            st_q, st_d;
  logic                  start_q, stop_q, run_en;
  logic [NUM_CH-1:0]     pend_vld, gnt_vec, drop_vec, sat_vec;
  logic [DATA_WIDTH-1:0] pend_data [NUM_CH];
  logic                  gnt_vld;
  logic [CH_BITS-1:0]    gnt_idx, rr_ptr;
  logic [DATA_WIDTH-1:0] gnt_data;
  int unsigned           drop_num;
  logic                  wr_vld_p2;
  logic [DATA_WIDTH-1:0] wr_data_p2;
  logic [CH_BITS-1:0]    wr_ch_p2;
  logic [DATA_WIDTH-1:0] drop_q;
  logic                  sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      st_q    <= WAIT_HIST;
    end else begin
      start_q <= start_from_pc;
      stop_q  <= stop_from_pc;
      st_q    <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      WAIT_HIST:  if (reset_done_from_hist) st_d = WAIT_START;
      WAIT_START: if (start_q && !stop_q)   st_d = RUN;
      RUN:        if (stop_q)               st_d = WAIT_START;
      default:    st_d = WAIT_HIST;
    endcase
  end

  // The RUN exit cycle already counts as stopped, which flushes every channel.
  always_comb begin
    run_en = (st_q == RUN) && !stop_q;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwc_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_ACCEPT (MIN_ACCEPT)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .run      (run_en),
      .pulse_in (pulse_sig_in[c]),
      .polarity (polarity_sel[c]),
      .grant    (gnt_vec[c]),
      .pend_vld (pend_vld[c]),
      .pend_data(pend_data[c]),
      .drop     (drop_vec[c]),
      .sat_hit  (sat_vec[c])
    );
  end

  // Round-robin: channels at or above the pointer first, then the wrapped ones.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_vec  = '0;
    gnt_data = '0;
    if (run_en && !wrfull_from_FIFO) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!gnt_vld && pend_vld[c] && (c >= int'(rr_ptr))) begin
          gnt_vld    = 1'b1;
          gnt_idx    = CH_BITS'(c);
          gnt_vec[c] = 1'b1;
          gnt_data   = pend_data[c];
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!gnt_vld && pend_vld[c] && (c < int'(rr_ptr))) begin
          gnt_vld    = 1'b1;
          gnt_idx    = CH_BITS'(c);
          gnt_vec[c] = 1'b1;
          gnt_data   = pend_data[c];
        end
      end
    end
  end

  always_comb begin
    drop_num = 0;
    for (int c = 0; c < NUM_CH; c++) drop_num = drop_num + {31'd0, drop_vec[c]};
  end

  // Stage p2: registered FIFO write; a stop arriving now suppresses the exit-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_p2  <= 1'b0;
      wr_data_p2 <= '0;
      wr_ch_p2   <= '0;
      rr_ptr     <= '0;
      drop_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      wr_vld_p2 <= gnt_vld && !stop_from_pc;
      if (gnt_vld) begin
        wr_data_p2 <= gnt_data;
        wr_ch_p2   <= gnt_idx;
        rr_ptr     <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_BITS'(1);
      end
      drop_q <= sat_add(drop_q, drop_num);
      sat_q  <= sat_q | (|sat_vec);
    end
  end

  assign wrreq_to_FIFO             = wr_vld_p2;
  assign data_to_compute_histogram = wr_data_p2;
  assign ch_id_to_fifo             = wr_ch_p2;
  assign drop_count                = drop_q;
  assign sat_flag                  = sat_q;

endmodule

// File: tb/tb_pulse_width_multi.sv
// Directed bench with a result scoreboard for pulse_width_multi (default and 4-bit instances).
module tb_pulse_width_multi;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ch;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        reset_done;
  logic [3:0]  pulse, pulse2, pol;
  logic        start, stop, wrfull;
  logic [15:0] data, drop;
  logic [1:0]  ch_id;
  logic        wrreq, sat;
  logic [3:0]  data2, drop2;
  logic [1:0]  ch_id2;
  logic        wrreq2, sat2;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  pulse_width_multi u_dut (
    .clk                      (clk),
    .reset                    (reset),
    .reset_done_from_hist     (reset_done),
    .pulse_sig_in             (pulse),
    .polarity_sel             (pol),
    .start_from_pc            (start),
    .stop_from_pc             (stop),
    .data_to_compute_histogram(data),
    .ch_id_to_fifo            (ch_id),
    .wrreq_to_FIFO            (wrreq),
    .wrfull_from_FIFO         (wrfull),
    .drop_count               (drop),
    .sat_flag                 (sat)
  );

  pulse_width_multi #(.DATA_WIDTH(4)) u_dut4 (
    .clk                      (clk),
    .reset                    (reset),
    .reset_done_from_hist     (reset_done),
    .pulse_sig_in             (pulse2),
    .polarity_sel             (pol),
    .start_from_pc            (start),
    .stop_from_pc             (stop),
    .data_to_compute_histogram(data2),
    .ch_id_to_fifo            (ch_id2),
    .wrreq_to_FIFO            (wrreq2),
    .wrfull_from_FIFO         (wrfull),
    .drop_count               (drop2),
    .sat_flag                 (sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrreq) obs_q.push_back('{data, ch_id});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int c);
    exp_q.push_back('{16'(d), 2'(c)});
  endtask

  task automatic pulse_mask(input logic [3:0] m, input int n);
    pulse = pulse ^ m;
    cyc(n);
    pulse = pulse ^ m;
  endtask

  task automatic drain(input string tag, input int maxc);
    rec_t e, o;
    int   n;
    n = 0;
    while ((obs_q.size() < exp_q.size()) && (n < maxc)) begin
      @(posedge clk);
      n++;
    end
    cyc(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else                  o = '{16'hFFFF, 2'b11};
      chk({tag, " data"}, (obs_q.size() >= 0) ? {16'd0, o.data} : 32'hFFFF_FFFF, {16'd0, e.data});
      chk({tag, " ch_id"}, {30'd0, o.ch}, {30'd0, e.ch});
    end
    chk({tag, " extra writes"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    bit found;
    reset = 1'b1; reset_done = 1'b0; start = 1'b0; stop = 1'b0; wrfull = 1'b0;
    pol = 4'b1011; pulse = 4'b0100; pulse2 = 4'b0100;
    cyc(3);
    chk("reset wrreq", wrreq, 0);
    chk("reset data", data, 0);
    chk("reset ch_id", ch_id, 0);
    chk("reset drop_count", drop, 0);
    chk("reset sat_flag", sat, 0);
    chk("reset wrreq dut4", wrreq2, 0);
    reset = 1'b0;
    cyc(1);
    reset_done = 1'b1;
    cyc(3);
    start = 1'b1;
    cyc(6);
    drain("bring-up", 0);

    // ch0 high for 10 cycles; write lands 4 edges after the raw fall
    push(10, 0);
    pulse_mask(4'b0001, 10);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("latency early wrreq", wrreq, 0);
    end
    cyc(1);
    chk("latency wrreq", wrreq, 1);
    drain("ch0 w10", 10);

    // ch2 measures low time; its high stretch yields nothing
    push(7, 2);
    pulse_mask(4'b0100, 7);
    drain("ch2 low7", 10);
    cyc(10);
    drain("ch2 high", 0);

    // pointer to 0 via ch3, then two full bursts, then a burst from ch2
    push(5, 3);
    pulse_mask(4'b1000, 5);
    drain("ch3 single", 10);
    push(5, 0); push(5, 1); push(5, 2); push(5, 3);
    pulse_mask(4'b1111, 5);
    cyc(3);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("burst back-to-back wrreq", wrreq, 1);
    end
    drain("burst1", 10);
    push(5, 0); push(5, 1); push(5, 2); push(5, 3);
    pulse_mask(4'b1111, 5);
    drain("burst wrap", 12);
    push(5, 1);
    pulse_mask(4'b0010, 5);
    drain("ch1 single", 10);
    push(5, 2); push(5, 3); push(5, 0); push(5, 1);
    pulse_mask(4'b1111, 5);
    drain("burst rr from ch2", 12);

    // back-pressure: second ch1 result is dropped
    wrfull = 1'b1;
    push(3, 1);
    pulse_mask(4'b0010, 3);
    cyc(3);
    pulse_mask(4'b0010, 4);
    cyc(8);
    chk("wrfull drop_count", drop, 1);
    chk("wrfull no writes", obs_q.size(), 0);
    wrfull = 1'b0;
    drain("wrfull release", 10);
    chk("drop_count after release", drop, 1);

    // pulse already active at start is ignored
    stop = 1'b1;
    cyc(4);
    pulse = pulse | 4'b0001;
    cyc(3);
    stop = 1'b0;
    cyc(8);
    pulse = pulse & 4'b1110;
    cyc(10);
    drain("armed at start", 0);
    push(6, 0);
    pulse_mask(4'b0001, 6);
    drain("ch0 after restart", 10);

    // stop mid-pulse on ch3, and a ch1 write that would land in the stop cycle
    pulse = pulse | 4'b1000;
    cyc(2);
    pulse_mask(4'b0010, 3);
    cyc(3);
    stop = 1'b1;
    cyc(1);
    chk("stop cycle wrreq", wrreq, 0);
    cyc(3);
    pulse = pulse & 4'b0111;
    cyc(3);
    stop = 1'b0;
    cyc(10);
    drain("stop flush", 0);
    chk("drop_count after stop", drop, 1);

    // short pulse: filtered only when the min-width build option is on
`ifndef PWC_MIN_WIDTH_FILTER_EN
    push(3, 0);
`endif
    pulse_mask(4'b0001, 3);
    drain("min width", 10);
    chk("drop_count after short pulse", drop, 1);
    chk("sat_flag dut16", sat, 0);

    // 4-bit instance saturates at 15
    chk("sat_flag dut4 before", sat2, 0);
    pulse2 = pulse2 | 4'b0001;
    cyc(20);
    pulse2 = pulse2 & 4'b1110;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1);
      if (wrreq2) found = 1'b1;
    end
    chk("dut4 write seen", found, 1);
    chk("dut4 data", data2, 15);
    chk("dut4 ch_id", ch_id2, 0);
    chk("dut4 sat_flag", sat2, 1);
    chk("dut4 drop_count", drop2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
